mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- RV32I memory stage: consumes the execute stage's ALU result (effective address or pass-through value) and store data, and performs loads/stores over a single-outstanding req/ack data-memory bus.
- Stalls upstream while a bus transaction is pending.
- Presents a registered result (load data or ALU value) plus destination register info to writeback.

Parameters:
- TIMEOUT_CYCLES, 256: max cycles waiting for dmem_ack before aborting with mem_err; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- valid_in  in  1  instruction from execute stage is valid
- ready_out  out  1  stage can accept (high only in IDLE)
- mem_read  in  1  load instruction
- mem_write  in  1  store instruction
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- alu_result  in  32  address (mem op) or result (non-mem op)
- store_data  in  32  rs2 value for stores
- rd_in  in  5  destination register
- reg_write_in  in  1  instruction writes rd
- dmem_req  out  1  bus request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address ({alu_result[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  transaction complete; rdata valid same cycle
- dmem_rdata  in  32  read word
- valid_out  out  1  result valid (one-cycle pulse per instruction)
- result  out  32  writeback value
- rd_out  out  5  destination register
- reg_write_out  out  1  writeback enable (forced 0 on error or store)
- mem_err  out  1  misaligned/illegal/timeout, qualified by valid_out

Behaviour:
- Reset: state IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, valid_out, result, rd_out, reg_write_out, mem_err all 0; timeout counter 0; ready_out=1.
- Accept = valid_in && state==IDLE; ready_out is combinational (state==IDLE). valid_in while not ready is ignored; upstream holds its inputs.
- Non-mem op (mem_read=mem_write=0): next edge valid_out=1, result=alu_result, rd/reg_write passed. Latency 1. State stays IDLE.
- Error check at accept:
  - mem_read && mem_write both set: error.
  - funct3 not in {000,001,010}, or store with 100/101: error.
  - H/HU with addr[0]=1: error.
  - W with addr[1:0]!=0: error.
  - On error: no bus request; next edge valid_out=1, mem_err=1, reg_write_out=0, result=alu_result. Latency 1.
- Legal mem op: next edge state=BUSY, dmem_req=1, with addr/we/be/wdata registered and stable until ack.
  - Byte enables: SB/LB be=1<<addr[1:0]; H be=addr[1]?1100:0011; W be=1111.
  - wdata: byte replicated x4, halfword replicated x2, or word.
- BUSY, dmem_ack=1: next edge dmem_req=0, state=IDLE, valid_out=1.
  - Load result: lane selected by addr[1:0], sign-extended (B/H) or zero-extended (BU/HU).
  - Store: reg_write_out=0, result=0.
  - Minimum memory latency is 2 edges from accept (ack in the first req cycle).
- Timeout: counter increments each BUSY cycle without ack. On reaching TIMEOUT_CYCLES, same exit as ack but with mem_err=1, reg_write_out=0; drop the request. Counter clears on entering BUSY.
- ack outside BUSY is ignored. An ack coinciding with the timeout terminal count counts as an ack (no error).
- valid_out is high for exactly one cycle per accepted instruction. result, rd_out, reg_write_out and mem_err hold until the next valid_out.
- Reset mid-BUSY: dmem_req drops asynchronously, no valid_out is produced, and the transaction is abandoned.

Decomposition:
- Shared riscv_pkg:
  - funct3 load/store constants (F3_B/H/W/BU/HU).
  - Stage state encoding (IDLE, BUSY).
  - XLEN=32.
- One combinational sub-module, mem_align:
  - Inputs: funct3, addr[1:0], store_data, rdata.
  - Outputs: be, wdata, load_ext, misalign/illegal flags.
  - The FSM, timeout counter and output registers remain in mem_stage.

Test Plan:
- Non-mem op, alu_result=0x1234_5678, rd=5 -> next cycle valid_out=1, result=0x12345678, rd_out=5, dmem_req never asserted.
- SB, addr=0x103, store_data=0xAB -> dmem_addr=0x100, be=1000, wdata=0xABABABAB; ack after 3 cycles -> valid_out one cycle later, reg_write_out=0, ready_out low throughout BUSY.
- LB addr=0x102, rdata=0x0080_0000 -> result=0xFFFFFF80. LBU on the same inputs -> result=0x00000080. LHU addr=0x102, rdata=0xBEEF_0000 -> result=0x0000BEEF.
- LW addr=0x101 -> no dmem_req, valid_out next cycle with mem_err=1, reg_write_out=0. SH addr=0x3 -> same response.
- TIMEOUT_CYCLES=4, ack never arrives -> dmem_req high 4 cycles then drops, valid_out with mem_err=1. A follow-up LW at an aligned address with immediate ack completes normally.
- rst_n low mid-BUSY -> dmem_req=0 immediately, no valid_out; after release ready_out=1 and the next op is accepted.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: XLEN, load/store funct3 codes
// and the memory stage state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables,
// store replication, load extraction/extension and legality.
module mem_align
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic            is_store,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_ext,
  output logic            misalign,
  output logic            illegal
);

  logic       is_b;
  logic       is_h;
  logic       is_w;
  logic       is_u;
  logic [7:0] lane_b;
  logic [15:0] lane_h;

  assign is_b = (funct3 == F3_B) || (funct3 == F3_BU);
  assign is_h = (funct3 == F3_H) || (funct3 == F3_HU);
  assign is_w = (funct3 == F3_W);
  assign is_u = (funct3 == F3_BU) || (funct3 == F3_HU);

  assign illegal  = !(is_b || is_h || is_w)
                  || (is_store && is_u);
  assign misalign = (is_h && addr[0])
                  || (is_w && (addr != 2'b00));

  always_comb begin
    lane_b = rdata[7:0];
    unique case (addr)
      2'd0: lane_b = rdata[7:0];
      2'd1: lane_b = rdata[15:8];
      2'd2: lane_b = rdata[23:16];
      2'd3: lane_b = rdata[31:24];
      default: lane_b = rdata[7:0];
    endcase
    lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be       = 4'b0000;
    wdata    = '0;
    load_ext = '0;
    unique case (1'b1)
      is_b: begin
        be       = 4'b0001 << addr;
        wdata    = {4{store_data[7:0]}};
        load_ext = is_u ? {24'b0, lane_b}
                        : {{24{lane_b[7]}}, lane_b};
      end
      is_h: begin
        be       = addr[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{store_data[15:0]}};
        load_ext = is_u ? {16'b0, lane_h}
                        : {{16{lane_h[15]}}, lane_h};
      end
      is_w: begin
        be       = 4'b1111;
        wdata    = store_data;
        load_ext = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: single-outstanding req/ack data bus,
// upstream stall while busy, registered writeback outputs.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        mem_err
);

  localparam logic [31:0] TLIM =
    32'(TIMEOUT_CYCLES - 1);

  mem_state_e  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic [31:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  rdo_q, rdo_d;
  logic        rwo_q, rwo_d;
  logic        err_q, err_d;

  logic        busy;
  logic [2:0]  f3_a;
  logic [1:0]  off_a;
  logic [3:0]  be_a;
  logic [31:0] wdata_a;
  logic [31:0] ld_a;
  logic        mis_a;
  logic        ill_a;
  logic        is_mem;
  logic        bad;
  logic        tmo;

  assign busy  = (state_q == BUSY);
  // one aligner serves the accept path and the load return
  assign f3_a  = busy ? f3_q  : funct3;
  assign off_a = busy ? off_q : alu_result[1:0];

  mem_align u_align (
    .funct3     (f3_a),
    .addr       (off_a),
    .is_store   (mem_write),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .be         (be_a),
    .wdata      (wdata_a),
    .load_ext   (ld_a),
    .misalign   (mis_a),
    .illegal    (ill_a)
  );

  assign is_mem = mem_read || mem_write;
  assign bad    = (mem_read && mem_write)
                || ill_a || mis_a;
  assign tmo    = (TIMEOUT_CYCLES != 0)
                && (cnt_q == TLIM);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    res_d   = res_q;
    rdo_d   = rdo_q;
    rwo_d   = rwo_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (!is_mem || bad) begin
            valid_d = 1'b1;
            res_d   = alu_result;
            rdo_d   = rd_in;
            rwo_d   = !is_mem && reg_write_in;
            err_d   = is_mem;
          end else begin
            state_d = BUSY;
            req_d   = 1'b1;
            we_d    = mem_write;
            addr_d  = {alu_result[31:2], 2'b00};
            be_d    = be_a;
            wdata_d = wdata_a;
            f3_d    = funct3;
            off_d   = alu_result[1:0];
            rd_d    = rd_in;
            rw_d    = mem_read && reg_write_in;
            cnt_d   = '0;
          end
        end
      end
      BUSY: begin
        if (dmem_ack || tmo) begin
          state_d = IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          rdo_d   = rd_q;
          rwo_d   = dmem_ack && rw_q;
          err_d   = !dmem_ack;
          res_d   = (dmem_ack && !we_q) ? ld_a : '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      rdo_q   <= '0;
      rwo_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      rdo_q   <= rdo_d;
      rwo_q   <= rwo_d;
      err_q   <= err_d;
    end
  end

  assign ready_out     = (state_q == IDLE);
  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign valid_out     = valid_q;
  assign result        = res_q;
  assign rd_out        = rdo_q;
  assign reg_write_out = rwo_q;
  assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with TIMEOUT_CYCLES=4.
// Inputs driven and outputs sampled on the falling edge.
module tb_mem_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd_in = '0;
  logic        reg_write_in = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        valid_out;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic        mem_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .funct3        (funct3),
    .alu_result    (alu_result),
    .store_data    (store_data),
    .rd_in         (rd_in),
    .reg_write_in  (reg_write_in),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .valid_out     (valid_out),
    .result        (result),
    .rd_out        (rd_out),
    .reg_write_out (reg_write_out),
    .mem_err       (mem_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic issue(input logic rd_, wr_,
                       input logic [2:0] f3,
                       input logic [31:0] a, sd,
                       input logic [4:0] rdi,
                       input logic rw);
    chk("ready_before", 32'(ready_out), 32'd1);
    valid_in     = 1'b1;
    mem_read     = rd_;
    mem_write    = wr_;
    funct3       = f3;
    alu_result   = a;
    store_data   = sd;
    rd_in        = rdi;
    reg_write_in = rw;
    @(negedge clk);
    valid_in  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic req_chk(input logic we,
                         input logic [31:0] a,
                         input logic [3:0] be,
                         input logic [31:0] wd);
    chk("req", 32'(dmem_req), 32'd1);
    chk("we", 32'(dmem_we), 32'(we));
    chk("addr", dmem_addr, a);
    chk("be", 32'(dmem_be), 32'(be));
    if (we) chk("wdata", dmem_wdata, wd);
    chk("ready_busy", 32'(ready_out), 32'd0);
  endtask

  // ack in BUSY cycle k (k=1 is the first req cycle)
  task automatic bus(input int k,
                     input logic [31:0] rdata);
    for (int i = 1; i < k; i++) begin
      chk("req_hold", 32'(dmem_req), 32'd1);
      chk("ready_hold", 32'(ready_out), 32'd0);
      chk("vout_busy", 32'(valid_out), 32'd0);
      @(negedge clk);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    @(negedge clk);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'hA5A5_A5A5;
  endtask

  task automatic done(input logic [31:0] res,
                      input logic [4:0] rdx,
                      input logic rw,
                      input logic err,
                      input logic req);
    chk("vout", 32'(valid_out), 32'd1);
    chk("result", result, res);
    chk("rd_out", 32'(rdx), 32'(rd_out));
    chk("rw_out", 32'(reg_write_out), 32'(rw));
    chk("mem_err", 32'(mem_err), 32'(err));
    chk("req_after", 32'(dmem_req), 32'(req));
    @(negedge clk);
    chk("vout_pulse", 32'(valid_out), 32'd0);
    chk("result_hold", result, res);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_vout", 32'(valid_out), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 0, F3_W, 32'h1234_5678, 0, 5, 1);
    done(32'h1234_5678, 5, 1, 0, 0);

    issue(0, 1, F3_B, 32'h103, 32'hAB, 7, 1);
    req_chk(1, 32'h100, 4'b1000, 32'hABAB_ABAB);
    bus(3, 32'h0);
    done(32'h0, 7, 0, 0, 0);

    issue(1, 0, F3_B, 32'h102, 0, 3, 1);
    req_chk(0, 32'h100, 4'b0100, 0);
    bus(1, 32'h0080_0000);
    done(32'hFFFF_FF80, 3, 1, 0, 0);

    issue(1, 0, F3_BU, 32'h102, 0, 3, 1);
    bus(2, 32'h0080_0000);
    done(32'h0000_0080, 3, 1, 0, 0);

    issue(1, 0, F3_HU, 32'h102, 0, 4, 1);
    req_chk(0, 32'h100, 4'b1100, 0);
    bus(1, 32'hBEEF_0000);
    done(32'h0000_BEEF, 4, 1, 0, 0);

    issue(1, 0, F3_H, 32'h100, 0, 6, 1);
    req_chk(0, 32'h100, 4'b0011, 0);
    bus(1, 32'h1111_8001);
    done(32'hFFFF_8001, 6, 1, 0, 0);

    issue(0, 1, F3_W, 32'h200, 32'hDEAD_BEEF, 1, 0);
    req_chk(1, 32'h200, 4'b1111, 32'hDEAD_BEEF);
    bus(2, 0);
    done(32'h0, 1, 0, 0, 0);

    issue(0, 1, F3_H, 32'h102, 32'h1234_CAFE, 1, 0);
    req_chk(1, 32'h100, 4'b1100, 32'hCAFE_CAFE);
    bus(1, 0);
    done(32'h0, 1, 0, 0, 0);

    issue(1, 0, F3_W, 32'h101, 0, 9, 1);
    done(32'h101, 9, 0, 1, 0);
    issue(0, 1, F3_H, 32'h3, 32'h55, 9, 0);
    done(32'h3, 9, 0, 1, 0);
    issue(0, 1, F3_BU, 32'h40, 32'h55, 9, 0);
    done(32'h40, 9, 0, 1, 0);
    issue(1, 0, 3'b011, 32'h40, 0, 9, 1);
    done(32'h40, 9, 0, 1, 0);
    issue(1, 1, F3_W, 32'h40, 0, 9, 1);
    done(32'h40, 9, 0, 1, 0);

    issue(1, 0, F3_W, 32'h40, 0, 10, 1);
    for (int i = 0; i < 4; i++) begin
      chk("tmo_req", 32'(dmem_req), 32'd1);
      chk("tmo_vout", 32'(valid_out), 32'd0);
      @(negedge clk);
    end
    done(32'h0, 10, 0, 1, 0);

    issue(1, 0, F3_W, 32'h44, 0, 11, 1);
    bus(1, 32'hCAFE_F00D);
    done(32'hCAFE_F00D, 11, 1, 0, 0);

    issue(1, 0, F3_W, 32'h48, 0, 12, 1);
    bus(4, 32'h0BAD_F00D);
    done(32'h0BAD_F00D, 12, 1, 0, 0);

    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("idle_ack_vout", 32'(valid_out), 32'd0);
    chk("idle_ack_rdy", 32'(ready_out), 32'd1);

    issue(1, 0, F3_W, 32'h80, 0, 13, 1);
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("async_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    chk("rst_busy_vout", 32'(valid_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_vout", 32'(valid_out), 32'd0);
    chk("post_rst_rdy", 32'(ready_out), 32'd1);
    issue(0, 0, F3_B, 32'h0000_00FE, 0, 14, 1);
    done(32'h0000_00FE, 14, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
